// File: rtl/opensync_pkg.sv
// -----------------------------------------------------------------------------
// opensync_pkg
// Shared constants and types for the OpenSync pit-record logic (TX and RX).
//
// Contents:
//   OPENSYNC_ETYPE / OPENSYNC_TYPE / OPENSYNC_SUBTYPE : frame identification
//   *_OFS / PIT_LEN : byte offsets within the frame (index 0 = DA[47:40])
//   BYTE_CNT_MAX    : saturation value of the per-frame byte counter
//   tx_pit_state_t  : state encoding of the transmit pit-record FSM
// -----------------------------------------------------------------------------
package opensync_pkg;

    localparam logic [15:0] OPENSYNC_ETYPE   = 16'hFF01;
    localparam logic [7:0]  OPENSYNC_TYPE    = 8'h06;
    localparam logic [7:0]  OPENSYNC_SUBTYPE = 8'h03;

    localparam logic [5:0]  ETYPE_OFS    = 6'd12;
    localparam logic [5:0]  TYPE_OFS     = 6'd14;
    localparam logic [5:0]  SUBTYPE_OFS  = 6'd15;
    localparam logic [5:0]  PIT_OFS      = 6'd24;
    localparam logic [5:0]  PIT_LEN      = 6'd8;
    localparam logic [5:0]  CORR_OFS     = 6'd32;
    localparam logic [5:0]  PIT_LAST     = PIT_OFS + PIT_LEN - 6'd1;
    localparam logic [5:0]  BYTE_CNT_MAX = 6'd63;

    typedef enum logic [1:0] {
        IDLE_S,
        CLASSIFY_S,
        STAMP_S,
        TRANSMIT_PKT_S
    } tx_pit_state_t;

endpackage

// File: rtl/opensync_transmit_pit_record.sv
// -----------------------------------------------------------------------------
// opensync_transmit_pit_record
// Passes the MAC TX byte stream to the PHY with one cycle of latency. In
// OpenSync frames (ethertype 0xFF01, type 0x06, subtype 0x03) it overwrites
// bytes 24..31 with the local transmit time captured at the first byte of the
// frame plus a fixed delay compensation. The FCS is regenerated downstream.
//
// Ports:
//   i_clk          : 125 MHz clock
//   i_rst_n        : synchronous active-low reset
//   iv_local_time  : free-running local time
//   iv_data        : TX frame byte (first byte = DA[47:40])
//   i_data_wr      : byte valid, contiguous high for a whole frame
//   ov_data        : byte to PHY (0 when o_data_wr is low)
//   o_data_wr      : valid to PHY
//   o_pit_stamped  : pulse in the cycle the last stamp byte is output
//   ov_pit_time    : stamp value of the most recently stamped frame
// -----------------------------------------------------------------------------
module opensync_transmit_pit_record
    import opensync_pkg::*;
#(
    parameter logic [63:0] TX_DELAY_COMP    = 64'd8,
    parameter logic [15:0] OPENSYNC_ETYPE   = opensync_pkg::OPENSYNC_ETYPE,
    parameter logic [7:0]  OPENSYNC_TYPE    = opensync_pkg::OPENSYNC_TYPE,
    parameter logic [7:0]  OPENSYNC_SUBTYPE = opensync_pkg::OPENSYNC_SUBTYPE
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [63:0] iv_local_time,
    input  logic [7:0]  iv_data,
    input  logic        i_data_wr,
    output logic [7:0]  ov_data,
    output logic        o_data_wr,
    output logic        o_pit_stamped,
    output logic [63:0] ov_pit_time
);

    tx_pit_state_t state;
    logic [5:0]    rv_byte_cnt;
    logic          rv_match;
    logic [63:0]   rv_tx_time;

    logic          match_next;
    logic          in_pit;
    logic [2:0]    pit_sel;
    logic [7:0]    pit_byte;

    // Running match of the header bytes, including the byte on the input this
    // cycle, so the decision at SUBTYPE_OFS already sees the subtype byte.
    always_comb begin
        match_next = rv_match;
        if (rv_byte_cnt == 6'd0)
            match_next = 1'b1;
        else if (rv_byte_cnt == ETYPE_OFS)
            match_next = rv_match && (iv_data == OPENSYNC_ETYPE[15:8]);
        else if (rv_byte_cnt == ETYPE_OFS + 6'd1)
            match_next = rv_match && (iv_data == OPENSYNC_ETYPE[7:0]);
        else if (rv_byte_cnt == TYPE_OFS)
            match_next = rv_match && (iv_data == OPENSYNC_TYPE);
        else if (rv_byte_cnt == SUBTYPE_OFS)
            match_next = rv_match && (iv_data == OPENSYNC_SUBTYPE);
    end

    // PIT_OFS is a multiple of 8, so the low three index bits select the
    // byte lane directly: index 24 -> [63:56], index 31 -> [7:0].
    always_comb begin
        in_pit   = (rv_byte_cnt >= PIT_OFS) && (rv_byte_cnt <= PIT_LAST);
        pit_sel  = 3'd7 - rv_byte_cnt[2:0];
        pit_byte = rv_tx_time[{pit_sel, 3'b000} +: 8];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state         <= IDLE_S;
            rv_byte_cnt   <= 6'd0;
            rv_match      <= 1'b0;
            rv_tx_time    <= 64'd0;
            ov_data       <= 8'd0;
            o_data_wr     <= 1'b0;
            o_pit_stamped <= 1'b0;
            ov_pit_time   <= 64'd0;
        end else begin
            o_pit_stamped <= 1'b0;
            if (!i_data_wr) begin
                // Frame end (or idle): any state returns to IDLE_S.
                state       <= IDLE_S;
                rv_byte_cnt <= 6'd0;
                ov_data     <= 8'd0;
                o_data_wr   <= 1'b0;
            end else begin
                o_data_wr <= 1'b1;
                ov_data   <= iv_data;
                rv_match  <= match_next;
                if (rv_byte_cnt != BYTE_CNT_MAX)
                    rv_byte_cnt <= rv_byte_cnt + 6'd1;

                case (state)
                    IDLE_S: begin
                        rv_tx_time <= iv_local_time + TX_DELAY_COMP;
                        state      <= CLASSIFY_S;
                    end
                    CLASSIFY_S: begin
                        if (rv_byte_cnt == SUBTYPE_OFS)
                            state <= match_next ? STAMP_S : TRANSMIT_PKT_S;
                    end
                    STAMP_S: begin
                        if (in_pit)
                            ov_data <= pit_byte;
                        if (rv_byte_cnt == PIT_LAST) begin
                            o_pit_stamped <= 1'b1;
                            ov_pit_time   <= rv_tx_time;
                            state         <= TRANSMIT_PKT_S;
                        end
                    end
                    TRANSMIT_PKT_S: begin
                        state <= TRANSMIT_PKT_S;
                    end
                    default: begin
                        state <= IDLE_S;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_opensync_transmit_pit_record.sv
// -----------------------------------------------------------------------------
// tb_opensync_transmit_pit_record
// Self-checking bench: every driven cycle pushes the expected output of the
// following cycle into a queue; the observed output is queued alongside and
// each test task pops and compares both.
// -----------------------------------------------------------------------------
module tb_opensync_transmit_pit_record;
    import opensync_pkg::*;

    typedef struct packed {
        logic       wr;
        logic [7:0] data;
        logic       pulse;
    } out_t;

    typedef logic [7:0] byte_q_t[$];

    localparam out_t IDLE_OUT = '0;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [63:0] iv_local_time = 64'd0;
    logic [7:0]  iv_data = 8'd0;
    logic        i_data_wr = 1'b0;
    logic [7:0]  ov_data;
    logic        o_data_wr;
    logic        o_pit_stamped;
    logic [63:0] ov_pit_time;

    out_t        exp_q[$];
    out_t        obs_q[$];
    logic [63:0] lt = 64'd0;
    logic [63:0] exp_pit = 64'd0;
    int          vectors = 0;
    int          miscompares = 0;
    int          cycle = 0;

    opensync_transmit_pit_record dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .iv_local_time(iv_local_time),
        .iv_data      (iv_data),
        .i_data_wr    (i_data_wr),
        .ov_data      (ov_data),
        .o_data_wr    (o_data_wr),
        .o_pit_stamped(o_pit_stamped),
        .ov_pit_time  (ov_pit_time)
    );

    always #4 i_clk = ~i_clk;

    // Drive one cycle, queue its expected result, then sample the result.
    task automatic step(input logic wr, input logic [7:0] d, input logic rst_n, input out_t e);
        out_t o;
        @(negedge i_clk);
        i_rst_n       = rst_n;
        i_data_wr     = wr;
        iv_data       = d;
        iv_local_time = lt;
        exp_q.push_back(e);
        @(posedge i_clk);
        #1;
        o.wr    = o_data_wr;
        o.data  = ov_data;
        o.pulse = o_pit_stamped;
        obs_q.push_back(o);
        lt    = lt + 64'd8;
        cycle = cycle + 1;
    endtask

    function automatic byte_q_t make_frame(input int len, input logic [15:0] et,
                                           input logic [7:0] ty, input logic [7:0] st);
        byte_q_t q;
        for (int i = 0; i < len; i++)
            q.push_back(8'($urandom_range(0, 255)));
        if (len > 15) begin
            q[12] = et[15:8];
            q[13] = et[7:0];
            q[14] = ty;
            q[15] = st;
        end
        return q;
    endfunction

    // Reference: frame-level view, the whole header is known up front.
    function automatic out_t model_out(input byte_q_t q, input int idx, input logic [63:0] t0);
        out_t        o;
        logic [63:0] stamp;
        logic        hit;
        hit = 1'b0;
        if (q.size() >= 16)
            hit = (q[12] == 8'hFF) && (q[13] == 8'h01) && (q[14] == 8'h06) && (q[15] == 8'h03);
        stamp   = t0 + 64'd8;
        o.wr    = 1'b1;
        o.data  = q[idx];
        o.pulse = 1'b0;
        if (hit && idx >= 24 && idx <= 31) begin
            o.data  = stamp[8*(31-idx) +: 8];
            o.pulse = (idx == 31);
        end
        return o;
    endfunction

    // Send a frame followed by one idle cycle; optionally hold reset low for
    // rst_len bytes starting at index rst_at (the rest of the frame is new).
    task automatic run_frame(input byte_q_t q, input logic [63:0] t0,
                             input int rst_at, input int rst_len);
        byte_q_t     cur;
        int          base;
        logic [63:0] tcur;
        out_t        e;
        cur  = q;
        base = 0;
        lt   = t0;
        tcur = t0;
        for (int i = 0; i < q.size(); i++) begin
            if (rst_at >= 0 && i >= rst_at && i < rst_at + rst_len) begin
                step(1'b1, q[i], 1'b0, IDLE_OUT);
                exp_pit = 64'd0;
                base    = i + 1;
                tcur    = lt;
                cur.delete();
                for (int k = i + 1; k < q.size(); k++)
                    cur.push_back(q[k]);
            end else begin
                e = model_out(cur, i - base, tcur);
                if (e.pulse)
                    exp_pit = tcur + 64'd8;
                step(1'b1, q[i], 1'b1, e);
            end
        end
        step(1'b0, 8'h00, 1'b1, IDLE_OUT);
    endtask

    task automatic test_reset();
        out_t e, o;
        step(1'b1, 8'hAA, 1'b0, IDLE_OUT);
        step(1'b1, 8'h55, 1'b0, IDLE_OUT);
        step(1'b0, 8'h00, 1'b1, IDLE_OUT);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL reset_out: got wr=%b data=%h pulse=%b, expected wr=%b data=%h pulse=%b",
                         o.wr, o.data, o.pulse, e.wr, e.data, e.pulse);
            end
        end
        vectors++;
        if (ov_pit_time !== 64'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_pit_time: got %h, expected 0", ov_pit_time);
        end
        vectors++;
        if (dut.state !== IDLE_S) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got %0d, expected %0d", dut.state, IDLE_S);
        end
    endtask

    task automatic test_passthrough();
        out_t e, o;
        run_frame(make_frame(64, 16'h0800, 8'h06, 8'h03), 64'h0000_0000_0000_4000, -1, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL passthrough: got wr=%b data=%h pulse=%b, expected wr=%b data=%h pulse=%b",
                         o.wr, o.data, o.pulse, e.wr, e.data, e.pulse);
            end
        end
        vectors++;
        if (ov_pit_time !== 64'd0) begin
            miscompares++;
            $display("[TB] FAIL passthrough_pit_time: got %h, expected 0", ov_pit_time);
        end
    endtask

    task automatic test_stamp();
        out_t e, o;
        int   n;
        n = 0;
        run_frame(make_frame(64, 16'hFF01, 8'h06, 8'h03), 64'h0000_0000_1234_5600, -1, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n++;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL stamp byte %0d: got wr=%b data=%h pulse=%b, expected wr=%b data=%h pulse=%b",
                         n - 1, o.wr, o.data, o.pulse, e.wr, e.data, e.pulse);
            end
        end
        vectors++;
        if (ov_pit_time !== 64'h0000_0000_1234_5608) begin
            miscompares++;
            $display("[TB] FAIL stamp_pit_time: got %h, expected 0000000012345608", ov_pit_time);
        end
    endtask

    task automatic test_wrong_subtype();
        out_t e, o;
        run_frame(make_frame(64, 16'hFF01, 8'h06, 8'h04), 64'h0000_0000_0000_9000, -1, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL wrong_subtype: got wr=%b data=%h pulse=%b, expected wr=%b data=%h pulse=%b",
                         o.wr, o.data, o.pulse, e.wr, e.data, e.pulse);
            end
        end
        vectors++;
        if (ov_pit_time !== 64'h0000_0000_1234_5608) begin
            miscompares++;
            $display("[TB] FAIL wrong_subtype_pit_time: got %h, expected 0000000012345608", ov_pit_time);
        end
    endtask

    task automatic test_short_frame();
        out_t e, o;
        run_frame(make_frame(28, 16'hFF01, 8'h06, 8'h03), 64'hDEAD_BEEF_0000_0000, -1, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL short_frame: got wr=%b data=%h pulse=%b, expected wr=%b data=%h pulse=%b",
                         o.wr, o.data, o.pulse, e.wr, e.data, e.pulse);
            end
        end
        vectors++;
        if (dut.state !== IDLE_S) begin
            miscompares++;
            $display("[TB] FAIL short_frame_state: got %0d, expected %0d", dut.state, IDLE_S);
        end
        vectors++;
        if (ov_pit_time !== 64'h0000_0000_1234_5608) begin
            miscompares++;
            $display("[TB] FAIL short_frame_pit_time: got %h, expected 0000000012345608", ov_pit_time);
        end
    endtask

    task automatic test_back_to_back();
        out_t e, o;
        int   pulses;
        pulses = 0;
        run_frame(make_frame(64, 16'hFF01, 8'h06, 8'h03), 64'h100, -1, 0);
        run_frame(make_frame(64, 16'hFF01, 8'h06, 8'h03), 64'h200, -1, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (o.pulse === 1'b1)
                pulses++;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL back_to_back: got wr=%b data=%h pulse=%b, expected wr=%b data=%h pulse=%b",
                         o.wr, o.data, o.pulse, e.wr, e.data, e.pulse);
            end
        end
        vectors++;
        if (pulses != 2) begin
            miscompares++;
            $display("[TB] FAIL back_to_back_pulses: got %0d, expected 2", pulses);
        end
        vectors++;
        if (ov_pit_time !== 64'h208) begin
            miscompares++;
            $display("[TB] FAIL back_to_back_pit_time: got %h, expected 208", ov_pit_time);
        end
    endtask

    task automatic test_reset_mid_frame();
        out_t e, o;
        run_frame(make_frame(64, 16'hFF01, 8'h06, 8'h03), 64'h0000_0000_0000_7000, 20, 2);
        vectors++;
        if (ov_pit_time !== exp_pit) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_pit_time: got %h, expected %h", ov_pit_time, exp_pit);
        end
        run_frame(make_frame(64, 16'hFF01, 8'h06, 8'h03), 64'h0000_ABCD_0000_0000, -1, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL reset_mid_frame: got wr=%b data=%h pulse=%b, expected wr=%b data=%h pulse=%b",
                         o.wr, o.data, o.pulse, e.wr, e.data, e.pulse);
            end
        end
        vectors++;
        if (ov_pit_time !== 64'h0000_ABCD_0000_0008) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_restamp: got %h, expected 0000abcd00000008", ov_pit_time);
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_passthrough();
        test_stamp();
        test_wrong_subtype();
        test_short_frame();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
